// File: rtl/countdown_timer_pkg.sv
// Shared constants and state encoding for the countdown timer.
package countdown_pkg;

    localparam int WIDTH_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ILL  = 2'b11
    } state_t;

endpackage

// File: rtl/countdown_timer_dec_nbit.sv
// Gate-level borrow-chain decrementer: y = a - 1, borrow_out set only at a == 0.
module dec_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             borrow_out
);

    wire [WIDTH-1:0] w_y;
    wire [WIDTH-1:0] w_b;

    not u_y0 (w_y[0], a[0]);
    not u_b0 (w_b[0], a[0]);

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        wire w_na;
        not u_na (w_na, a[i]);
        xor u_y  (w_y[i], a[i], w_b[i-1]);
        and u_b  (w_b[i], w_na, w_b[i-1]);
    end

    assign y          = w_y;
    assign borrow_out = w_b[WIDTH-1];

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter with start handshake, done pulse and optional auto-reload.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_dec;
    logic             w_borrow;

    dec_nbit #(.WIDTH(WIDTH)) u_dec (
        .a          (r_count),
        .y          (w_dec),
        .borrow_out (w_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_count  <= load_val;
                        r_reload <= load_val;
                        r_state  <= (load_val == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        // a borrow means count is already 0: never wrap
                        if (!w_borrow)
                            r_count <= w_dec;
                        if (r_count == WIDTH'(1) || w_borrow)
                            r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (AUTO_RELOAD && r_reload != '0) begin
                        r_state <= ST_RUN;
                        r_count <= r_reload;
                    end else if (AUTO_RELOAD) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign count       = r_count;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: three configurations plus the decrementer.
module tb_countdown_timer;
    import countdown_pkg::*;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic       a_sv = 0, a_en = 0, a_ab = 0;
    logic [3:0] a_lv = 0;
    logic       a_rdy, a_busy, a_done;
    logic [3:0] a_cnt;

    logic       b_sv = 0, b_en = 0, b_ab = 0;
    logic [3:0] b_lv = 0;
    logic       b_rdy, b_busy, b_done;
    logic [3:0] b_cnt;

    logic       c_sv = 0, c_en = 0, c_ab = 0;
    logic [7:0] c_lv = 0;
    logic       c_rdy, c_busy, c_done;
    logic [7:0] c_cnt;

    logic [7:0] d_a = 0;
    logic [7:0] d_y;
    logic       d_bo;

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .start_valid(a_sv), .start_ready(a_rdy),
        .load_val(a_lv), .en(a_en), .abort(a_ab), .count(a_cnt),
        .busy(a_busy), .done(a_done));

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .start_valid(b_sv), .start_ready(b_rdy),
        .load_val(b_lv), .en(b_en), .abort(b_ab), .count(b_cnt),
        .busy(b_busy), .done(b_done));

    countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .start_valid(c_sv), .start_ready(c_rdy),
        .load_val(c_lv), .en(c_en), .abort(c_ab), .count(c_cnt),
        .busy(c_busy), .done(c_done));

    dec_nbit #(.WIDTH(8)) u_dec (.a(d_a), .y(d_y), .borrow_out(d_bo));

    task automatic chk(input string nm, input exp_t e, input exp_t act);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got cnt=%0d busy=%b done=%b rdy=%b, want cnt=%0d busy=%b done=%b rdy=%b",
                     nm, act.cnt, act.busy, act.done, act.rdy,
                     e.cnt, e.busy, e.done, e.rdy);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0)
            chk("A", qa.pop_front(), {4'h0, a_cnt, a_busy, a_done, a_rdy});
        if (qb.size() != 0)
            chk("B_reload", qb.pop_front(), {4'h0, b_cnt, b_busy, b_done, b_rdy});
        if (qc.size() != 0)
            chk("C_w8", qc.pop_front(), {c_cnt, c_busy, c_done, c_rdy});
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ((u_a.r_state == ST_RUN && a_en && u_a.w_borrow) ||
                (u_b.r_state == ST_RUN && b_en && u_b.w_borrow) ||
                (u_c.r_state == ST_RUN && c_en && u_c.w_borrow)) begin
                errors++;
                $display("FAIL borrow: borrow_out=1 while RUN&&en, want 0");
            end
        end
    end

    task automatic push(input int id, input int cnt,
                        input logic bz, input logic dn, input logic rd);
        exp_t e;
        e = '{cnt: 8'(cnt), busy: bz, done: dn, rdy: rd};
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic tick(input int id, input int cnt,
                        input logic bz, input logic dn, input logic rd);
        @(posedge clk);
        #1;
        push(id, cnt, bz, dn, rd);
    endtask

    initial begin
        // decrementer, exhaustive
        for (int i = 0; i < 256; i++) begin
            d_a = 8'(i);
            #1;
            checks++;
            if (d_y !== 8'(i - 1) || d_bo !== (i == 0)) begin
                errors++;
                $display("FAIL dec a=%0d: got y=%0d bo=%b, want y=%0d bo=%b",
                         i, d_y, d_bo, 8'(i - 1), (i == 0));
            end
        end

        // values during reset
        push(0, 0, 0, 0, 1);
        push(1, 0, 0, 0, 1);
        push(2, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic run, load 3
        a_sv = 1; a_lv = 4'd3; a_en = 1;
        tick(0, 3, 1, 0, 0);
        a_sv = 0;
        tick(0, 2, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 1);

        // zero load
        a_sv = 1; a_lv = 4'd0;
        tick(0, 0, 1, 1, 0);
        a_sv = 0;
        tick(0, 0, 0, 0, 1);

        // load 4 with two enable-low cycles at count 2
        a_sv = 1; a_lv = 4'd4;
        tick(0, 4, 1, 0, 0);
        a_sv = 0;
        tick(0, 3, 1, 0, 0);
        tick(0, 2, 1, 0, 0);
        a_en = 0;
        tick(0, 2, 1, 0, 0);
        tick(0, 2, 1, 0, 0);
        a_en = 1;
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 1);

        // abort at count 2
        a_sv = 1; a_lv = 4'd3;
        tick(0, 3, 1, 0, 0);
        a_sv = 0;
        tick(0, 2, 1, 0, 0);
        a_ab = 1;
        tick(0, 0, 0, 0, 1);
        a_ab = 0;
        tick(0, 0, 0, 0, 1);

        // abort together with start in IDLE
        a_sv = 1; a_lv = 4'd5; a_ab = 1;
        tick(0, 0, 0, 0, 1);
        a_sv = 0; a_ab = 0;
        tick(0, 0, 0, 0, 1);

        // start ignored while busy, load 15 is the max
        a_sv = 1; a_lv = 4'd15;
        tick(0, 15, 1, 0, 0);
        a_lv = 4'd2;
        tick(0, 14, 1, 0, 0);
        a_sv = 0;
        a_ab = 1;
        tick(0, 0, 0, 0, 1);
        a_ab = 0;

        // auto reload, period 3
        b_sv = 1; b_lv = 4'd2; b_en = 1;
        tick(1, 2, 1, 0, 0);
        b_sv = 0;
        tick(1, 1, 1, 0, 0);
        tick(1, 0, 1, 1, 0);
        b_en = 0;
        tick(1, 2, 1, 0, 0);
        b_en = 1;
        tick(1, 1, 1, 0, 0);
        tick(1, 0, 1, 1, 0);
        tick(1, 2, 1, 0, 0);
        b_ab = 1;
        tick(1, 0, 0, 0, 1);
        b_ab = 0;
        tick(1, 0, 0, 0, 1);

        // auto reload of zero keeps done high
        b_sv = 1; b_lv = 4'd0;
        tick(1, 0, 1, 1, 0);
        b_sv = 0;
        tick(1, 0, 1, 1, 0);
        tick(1, 0, 1, 1, 0);
        b_ab = 1;
        tick(1, 0, 0, 0, 1);
        b_ab = 0;

        // 8-bit full-scale run
        c_sv = 1; c_lv = 8'hFF; c_en = 1;
        tick(2, 255, 1, 0, 0);
        c_sv = 0;
        for (int k = 1; k < 255; k++)
            tick(2, 255 - k, 1, 0, 0);
        tick(2, 0, 1, 1, 0);
        tick(2, 0, 0, 0, 1);

        // async reset mid-run at count 5
        a_sv = 1; a_lv = 4'd7;
        tick(0, 7, 1, 0, 0);
        a_sv = 0;
        tick(0, 6, 1, 0, 0);
        tick(0, 5, 1, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 push(0, 0, 0, 0, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0",
                     qa.size() + qb.size() + qc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
